gnrl_sync_fifo: RTL
===================

GNRL_SYNC_FIFO -- requirements
Module: gnrl_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; legal values are powers of two, 2..64.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1, discards all stored entries.
REQ-006 SHALL have port i_vld, input, 1, write side offers data.
REQ-007 SHALL have port i_rdy, output, 1, FIFO can accept a write.
REQ-008 SHALL have port i_dat, input, DATA_WIDTH, write data.
REQ-009 SHALL have port o_vld, output, 1, read side data valid.
REQ-010 SHALL have port o_rdy, input, 1, reader accepts data.
REQ-011 SHALL have port o_dat, output, DATA_WIDTH, read data (head entry).
REQ-012 SHALL have port count, output, log2(DEPTH)+1, number of stored entries.

Function
REQ-013 SHALL define push = i_vld & i_rdy and pop = o_vld & o_rdy; a transfer occurs only on a cycle where both signals of that pair are high.
REQ-014 SHALL drive i_rdy = (count != DEPTH) & !flush.
REQ-015 SHALL drive o_vld = (count != 0) & !flush, except as modified by REQ-024.
REQ-016 SHALL present o_dat combinationally from the head entry, with no output register.
REQ-017 SHALL write i_dat into the tail entry on push, and advance the tail pointer by one, wrapping from DEPTH-1 to 0.
REQ-018 SHALL advance the head pointer by one on pop, wrapping from DEPTH-1 to 0.
REQ-019 SHALL update count as follows: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
REQ-020 SHALL, when full (count = DEPTH), refuse a push even if a pop occurs in the same cycle.
REQ-021 SHALL keep o_dat and o_vld stable while o_vld=1 and o_rdy=0.
REQ-022 SHALL, on flush, clear the head pointer, tail pointer and count to 0 on the next edge; flush overrides any push or pop in that cycle.
REQ-023 SHALL, in the default build, make a written entry visible on o_vld no earlier than one cycle after its push.

Reset
REQ-024 SHALL, while rst=1, asynchronously force the head pointer, tail pointer and count to 0; consequently i_rdy=1, o_vld=0 and count=0.
REQ-025 SHALL NOT reset the storage array; o_dat is don't-care while o_vld=0.
REQ-026 SHALL discard a transfer in progress when rst is asserted mid-operation, with no partial pointer update.

Configuration
REQ-027 SHALL, when macro GNRL_FIFO_BYPASS_EN is defined and count=0 and flush=0, drive o_vld=i_vld and o_dat=i_dat combinationally.
REQ-028 SHALL, in bypass mode when i_vld & o_rdy, not write the entry and not change the pointers or count; when i_vld & !o_rdy, write normally.
REQ-029 SHALL, when GNRL_FIFO_BYPASS_EN is undefined, have no bypass path; minimum latency is 1 cycle, per REQ-023.

Structure
REQ-030 SHALL place the DEPTH legality check and a shared log2 width macro in the common general-cells header, guarded like the other gnrl cells.
REQ-031 SHALL implement each pointer as sub-module gnrl_fifo_ptr (wrap-around counter with increment and clear), instantiated twice.
REQ-032 SHALL build all storage and pointer flops from load-enabled flop cells, with reset only on pointers and count.

Verification
REQ-033 SHALL cover fill and drain: DEPTH=4, push 0xA0..0xA3 with o_rdy=0 -> count=4, i_rdy=0; then o_rdy=1 -> reads 0xA0,0xA1,0xA2,0xA3 in order and count returns to 0.
REQ-034 SHALL cover simultaneous push and pop: count=2, i_vld=o_rdy=1 for 6 cycles -> count stays 2, order preserved, and the pointers wrap at least once.
REQ-035 SHALL cover full with pop: count=4, i_vld=1, o_rdy=1 -> exactly one pop occurs, no push, and count=3 on the next cycle.
REQ-036 SHALL cover flush with push: count=3, flush=1 together with i_vld=1 -> count=0 and o_vld=0 on the next cycle, and the pushed data is lost.
REQ-037 SHALL cover asynchronous reset: assert rst mid-stream between clock edges -> count=0, o_vld=0 and i_rdy=1 immediately, without waiting for a clock edge.
REQ-038 SHALL cover bypass: with GNRL_FIFO_BYPASS_EN, when empty and i_vld=1, o_rdy=1, i_dat=0x5A -> o_dat=0x5A in the same cycle and count remains 0.

Source files
------------

// File: rtl/gnrl_sync_fifo_pkg.sv
// Shared general-cells definitions and the gnrl_sync_fifo package.
//   GNRL_LOG2(n)        : index width for an n-entry structure.
//   GNRL_DEPTH_CHECK(d) : elaboration-time check that d is a power of two in 2..64.
//   gnrl_sync_fifo_pkg  : FIFO control payload, count-update opcode and its selector.
// No ports; compile this file before the other rtl/ files.

`ifndef GNRL_CELLS_SVH
`define GNRL_CELLS_SVH

`define GNRL_LOG2(n) $clog2(n)

`define GNRL_DEPTH_CHECK(d) \
  if (!(((d) >= 2) && ((d) <= 64) && ((((d) & ((d) - 1))) == 0))) begin : g_depth_illegal \
    $error("gnrl cell: DEPTH must be a power of two in 2..64"); \
  end

`endif

package gnrl_sync_fifo_pkg;

  // Per-cycle FIFO control decisions.
  typedef struct packed {
    logic clr;  // flush: clear pointers and count
    logic wr;   // store an entry at the tail
    logic rd;   // retire the head entry
  } fifo_ctl_t;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

  // Clear dominates; a simultaneous write and read leaves the count alone.
  function automatic cnt_op_e cnt_op_sel(input fifo_ctl_t ctl);
    cnt_op_e op;
    op = CNT_HOLD;
    if (ctl.clr) begin
      op = CNT_CLR;
    end else if (ctl.wr && !ctl.rd) begin
      op = CNT_INC;
    end else if (ctl.rd && !ctl.wr) begin
      op = CNT_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/gnrl_sync_fifo_ptr.sv
// Load-enabled flop cells and the FIFO wrap-around pointer.
//   gnrl_dffl  : load-enabled flop, no reset (storage).
//     clk, lden_i, d_i[DW] -> q_o[DW]
//   gnrl_dfflr : load-enabled flop, async active-high reset to 0.
//     clk, rst, lden_i, d_i[DW] -> q_o[DW]
//   gnrl_fifo_ptr : AW-bit pointer over 2**AW entries; clear beats increment.
//     clk, rst, clr_i, inc_i -> ptr_o[AW]

module gnrl_dffl #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (lden_i) begin
      dat_q <= d_i;
    end
  end

  assign q_o = dat_q;

endmodule

module gnrl_dfflr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] dat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
    end else if (lden_i) begin
      dat_q <= d_i;
    end
  end

  assign q_o = dat_q;

endmodule

module gnrl_fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic          ptr_ld;

  // Depth is 2**AW, so the natural AW-bit rollover is the wrap to 0.
  always_comb begin
    ptr_ld = clr_i | inc_i;
    ptr_d  = clr_i ? '0 : ptr_q + AW'(1);
  end

  gnrl_dfflr #(.DW(AW)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .lden_i (ptr_ld),
    .d_i    (ptr_d),
    .q_o    (ptr_q)
  );

  assign ptr_o = ptr_q;

endmodule

// File: rtl/gnrl_sync_fifo.sv
// Single-clock valid/ready FIFO with flush and async active-high reset.
// Optional feature macro: GNRL_FIFO_BYPASS_EN -- when defined, an empty FIFO
// forwards i_vld/i_dat straight to o_vld/o_dat; without it the minimum
// write-to-read latency is one cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : discard all stored entries on the next edge
//   i_vld/i_rdy/i_dat : write side handshake and data
//   o_vld/o_rdy/o_dat : read side handshake and head data (unregistered)
//   count             : number of stored entries, 0..DEPTH

module gnrl_sync_fifo
  import gnrl_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        i_vld,
  output logic                        i_rdy,
  input  logic [DATA_WIDTH-1:0]       i_dat,
  output logic                        o_vld,
  input  logic                        o_rdy,
  output logic [DATA_WIDTH-1:0]       o_dat,
  output logic [`GNRL_LOG2(DEPTH):0]  count
);

  localparam int unsigned AW = `GNRL_LOG2(DEPTH);
  localparam int unsigned CW = AW + 1;

  `GNRL_DEPTH_CHECK(DEPTH)

  logic [AW-1:0]                  head_q;
  logic [AW-1:0]                  tail_q;
  logic [CW-1:0]                  cnt_q;
  logic [CW-1:0]                  cnt_d;
  logic                           cnt_ld;
  cnt_op_e                        cnt_op;
  fifo_ctl_t                      ctl;
  logic [DEPTH-1:0]               wr_sel;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                           empty;
  logic                           full;
  logic                           push;
  logic                           pop;
  logic                           byp_hit;

  // Handshake, bypass forwarding and per-cycle control decisions.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    i_rdy   = !full && !flush;
    o_vld   = !empty && !flush;
    o_dat   = mem[head_q];
    byp_hit = 1'b0;
`ifdef GNRL_FIFO_BYPASS_EN
    if (empty && !flush) begin
      o_vld   = i_vld;
      o_dat   = i_dat;
      // Entry consumed in flight: nothing is stored and no state moves.
      byp_hit = i_vld && o_rdy;
    end
`endif
    push    = i_vld && i_rdy;
    pop     = o_vld && o_rdy;
    ctl.clr = flush;
    ctl.wr  = push && !byp_hit;
    ctl.rd  = pop && !byp_hit;
  end

  // Count update and storage write-enable decode.
  always_comb begin
    cnt_op = cnt_op_sel(ctl);
    cnt_ld = (cnt_op != CNT_HOLD);
    cnt_d  = cnt_q;
    unique case (cnt_op)
      CNT_INC: cnt_d = cnt_q + CW'(1);
      CNT_DEC: cnt_d = cnt_q - CW'(1);
      CNT_CLR: cnt_d = '0;
      default: cnt_d = cnt_q;
    endcase
    wr_sel = '0;
    if (ctl.wr) begin
      wr_sel[tail_q] = 1'b1;
    end
  end

  gnrl_dfflr #(.DW(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .lden_i (cnt_ld),
    .d_i    (cnt_d),
    .q_o    (cnt_q)
  );

  gnrl_fifo_ptr #(.AW(AW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ctl.clr),
    .inc_i (ctl.rd),
    .ptr_o (head_q)
  );

  gnrl_fifo_ptr #(.AW(AW)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ctl.clr),
    .inc_i (ctl.wr),
    .ptr_o (tail_q)
  );

  // Storage entries carry no reset; contents are don't-care while empty.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    gnrl_dffl #(.DW(DATA_WIDTH)) u_ent (
      .clk    (clk),
      .lden_i (wr_sel[i]),
      .d_i    (i_dat),
      .q_o    (mem[i])
    );
  end

  assign count = cnt_q;

endmodule
